// File: rtl/dino_sfx_player.sv
// Plays a clip of 16-bit samples from a synchronous ROM, one sample per sample_tick, with 0..3 bit attenuation.
// Latency: sample_valid rises on the third edge counting the one that samples the tick; output holds until ready.
module dino_sfx_player #(
    parameter int DEPTH      = 5000,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trigger,
    input  logic                  sample_tick,
    input  logic [1:0]            atten,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [15:0]           rom_data,
    output logic [15:0]           sample_out,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic [7:0]            underrun_count
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_TICK = 3'd1;
    localparam logic [2:0] READ      = 3'd2;
    localparam logic [2:0] LATCH     = 3'd3;
    localparam logic [2:0] OUTPUT    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           sample_out_q, sample_out_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  restart_pending_q, restart_pending_d;
    logic [7:0]            underrun_q, underrun_d;

    logic signed [15:0]    rom_s;
    logic signed [15:0]    rom_shifted;
    logic                  xfer;
    logic                  missed_tick;

    assign rom_s       = $signed(rom_data);
    assign rom_shifted = rom_s >>> atten;
    assign xfer        = sample_valid_q & sample_ready;
    assign missed_tick = sample_tick &
                         ((state_q == READ) || (state_q == LATCH) || (state_q == OUTPUT));

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        sample_out_d      = sample_out_q;
        sample_valid_d    = sample_valid_q;
        restart_pending_d = restart_pending_q;
        underrun_d        = underrun_q;

        if (missed_tick && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                // A tick arriving with the trigger is simply dropped.
                if (trigger) begin
                    addr_d     = '0;
                    underrun_d = 8'd0;
                    state_d    = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (trigger) begin
                    addr_d     = '0;
                    underrun_d = 8'd0;
                end else if (sample_tick) begin
                    state_d = READ;
                end
            end
            READ, LATCH: begin
                if (trigger) begin
                    addr_d     = '0;
                    underrun_d = 8'd0;
                    state_d    = WAIT_TICK;
                end else if (state_q == READ) begin
                    state_d = LATCH;
                end else begin
                    sample_out_d   = rom_shifted;
                    sample_valid_d = 1'b1;
                    state_d        = OUTPUT;
                end
            end
            OUTPUT: begin
                // The presented sample is never withdrawn; a restart waits for the handshake.
                if (trigger) begin
                    restart_pending_d = 1'b1;
                    underrun_d        = 8'd0;
                end
                if (xfer) begin
                    sample_valid_d = 1'b0;
                    if (restart_pending_q || trigger) begin
                        addr_d            = '0;
                        restart_pending_d = 1'b0;
                        underrun_d        = 8'd0;
                        state_d           = WAIT_TICK;
                    end else if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = WAIT_TICK;
                    end
                end
            end
            default: begin
                state_d           = IDLE;
                addr_d            = '0;
                sample_valid_d    = 1'b0;
                restart_pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            sample_out_q      <= 16'd0;
            sample_valid_q    <= 1'b0;
            restart_pending_q <= 1'b0;
            underrun_q        <= 8'd0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            sample_out_q      <= sample_out_d;
            sample_valid_q    <= sample_valid_d;
            restart_pending_q <= restart_pending_d;
            underrun_q        <= underrun_d;
        end
    end

    assign rom_address    = addr_q;
    assign sample_out     = sample_out_q;
    assign sample_valid   = sample_valid_q;
    assign busy           = (state_q != IDLE);
    assign underrun_count = underrun_q;

endmodule
